// File: rtl/tx_share_pkg.sv
// Shared types and constants for the transmitter-sharing controller.
// Holds the controller FSM states, transmitter command codes and word-width derivation.
package tx_share_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_DONE,
    S_ABORT,
    S_GAP
  } ctrl_state_t;

  localparam logic [1:0] TX_CMD_IDLE = 2'd0;
  localparam logic [1:0] TX_CMD_SEND = 2'd2;

  function automatic int unsigned data_width(input int unsigned base);
    return 32'd1 << base;
  endfunction

endpackage

// File: rtl/tx_share_ctrl_if.sv
// Requester and transmitter signal bundle for tx_share_ctrl.
// The controller uses the slave modport; requesters and the transmitter use master.
interface tx_share_ctrl_if #(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned DATA_WIDTH_BASE = 5
);
  import tx_share_pkg::*;

  localparam int unsigned W  = data_width(DATA_WIDTH_BASE);
  localparam int unsigned IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ*W-1:0] req_data;
  logic [NUM_REQ-1:0]   ack;
  logic                 ack_err;
  logic                 busy;
  logic [IW-1:0]        grant_idx;
  logic [1:0]           tx_state_in;
  logic [W-1:0]         tx_data;
  logic                 tx_finish_fsm;

  modport slave (
    input  req, req_data, tx_finish_fsm,
    output ack, ack_err, busy, grant_idx, tx_state_in, tx_data
  );

  modport master (
    output req, req_data, tx_finish_fsm,
    input  ack, ack_err, busy, grant_idx, tx_state_in, tx_data
  );

endinterface

// File: rtl/tx_share_ctrl_rr_arbiter.sv
// Combinational rotating-priority select: first set request at or after the pointer,
// wrapping around.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_ptr,
  output logic [IW-1:0]      o_winner,
  output logic               o_any
);

  int unsigned w_sum;
  logic [IW-1:0] w_idx;

  always_comb begin
    o_winner = '0;
    o_any    = 1'b0;
    w_sum    = 0;
    w_idx    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      // pointer is always below NUM_REQ, so a single subtraction wraps
      w_sum = 32'(i_ptr) + k;
      if (w_sum >= NUM_REQ) w_sum = w_sum - NUM_REQ;
      w_idx = w_sum[IW-1:0];
      if (!o_any && i_req[w_idx]) begin
        o_any    = 1'b1;
        o_winner = w_idx;
      end
    end
  end

endmodule

// File: rtl/tx_share_ctrl.sv
// Shares one serial transmitter between NUM_REQ requesters: round-robin grant,
// one-cycle send command, wait for end-of-frame or watchdog abort, then ack.
module tx_share_ctrl
  import tx_share_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned DATA_WIDTH_BASE = 5,
  parameter int unsigned TIMEOUT         = 1023
) (
  input logic           clk,
  input logic           rst,
  tx_share_ctrl_if.slave bus
);

  localparam int unsigned W  = data_width(DATA_WIDTH_BASE);
  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  ctrl_state_t         r_state, w_next;
  logic [IW-1:0]       r_ptr;
  logic [CW-1:0]       r_wd;
  logic [NUM_REQ-1:0]  r_ack, w_ack;
  logic                r_ack_err, w_ack_err;
  logic                r_busy;
  logic [IW-1:0]       r_grant;
  logic [1:0]          r_tx_cmd, w_tx_cmd;
  logic [W-1:0]        r_tx_data;
  logic [IW-1:0]       w_winner;
  logic                w_any;
  logic [W-1:0]        w_words [NUM_REQ];

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
    .i_req    (bus.req),
    .i_ptr    (r_ptr),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) w_words[i] = bus.req_data[i*W +: W];
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:          if (w_any) w_next = S_LAUNCH;
      S_LAUNCH:        w_next = S_WAIT;
      S_WAIT: begin
        if (bus.tx_finish_fsm)          w_next = S_DONE;
        else if (r_wd == CW'(TIMEOUT))  w_next = S_ABORT;
      end
      S_DONE, S_ABORT: w_next = S_GAP;
      S_GAP:           w_next = S_IDLE;
      default:         w_next = S_IDLE;
    endcase
  end

  // outputs are registered from the next state so they line up with the state they describe
  always_comb begin
    w_ack     = '0;
    w_ack_err = 1'b0;
    w_tx_cmd  = TX_CMD_IDLE;
    if (w_next == S_DONE || w_next == S_ABORT) w_ack[r_grant] = 1'b1;
    if (w_next == S_ABORT)  w_ack_err = 1'b1;
    if (w_next == S_LAUNCH) w_tx_cmd  = TX_CMD_SEND;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_wd      <= '0;
      r_ack     <= '0;
      r_ack_err <= 1'b0;
      r_busy    <= 1'b0;
      r_grant   <= '0;
      r_tx_cmd  <= TX_CMD_IDLE;
      r_tx_data <= '0;
    end else begin
      r_state   <= w_next;
      r_ack     <= w_ack;
      r_ack_err <= w_ack_err;
      r_busy    <= (w_next != S_IDLE);
      r_tx_cmd  <= w_tx_cmd;
      if (r_state == S_IDLE && w_any) begin
        r_grant   <= w_winner;
        r_tx_data <= w_words[w_winner];
      end
      if (r_state == S_LAUNCH)    r_wd <= '0;
      else if (r_state == S_WAIT) r_wd <= r_wd + 1'b1;
      if (r_state == S_DONE || r_state == S_ABORT)
        r_ptr <= (r_grant == IW'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
    end
  end

  assign bus.ack         = r_ack;
  assign bus.ack_err     = r_ack_err;
  assign bus.busy        = r_busy;
  assign bus.grant_idx   = r_grant;
  assign bus.tx_state_in = r_tx_cmd;
  assign bus.tx_data     = r_tx_data;

endmodule

// File: tb/tb_tx_share_ctrl.sv
// Scoreboard bench for tx_share_ctrl: two instances (long and short watchdog) with
// behavioural transmitter models; a monitor checks every ack against queued expectations.
module tb_tx_share_ctrl;
  import tx_share_pkg::*;

  typedef struct {
    int          idx;
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic rst;

  tx_share_ctrl_if #(.NUM_REQ(4), .DATA_WIDTH_BASE(5)) ifa ();
  tx_share_ctrl_if #(.NUM_REQ(4), .DATA_WIDTH_BASE(5)) ifb ();

  tx_share_ctrl #(.NUM_REQ(4), .DATA_WIDTH_BASE(5), .TIMEOUT(1023)) dut_a (
    .clk (clk), .rst (rst), .bus (ifa)
  );
  tx_share_ctrl #(.NUM_REQ(4), .DATA_WIDTH_BASE(5), .TIMEOUT(15)) dut_b (
    .clk (clk), .rst (rst), .bus (ifb)
  );

  exp_t exp_a[$];
  exp_t exp_b[$];
  int   n_vec;
  int   n_err;
  int   a_delay, b_delay, a_cnt, b_cnt;
  logic a_stray;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transmitter models: finish pulses 'delay' cycles after the send command (0 = never).
  initial begin
    ifa.tx_finish_fsm = 1'b0;
    a_cnt = 0;
    forever begin
      @(negedge clk);
      ifa.tx_finish_fsm = a_stray;
      if (!rst) a_cnt = 0;
      else if (a_cnt > 0) begin
        a_cnt--;
        if (a_cnt == 0) ifa.tx_finish_fsm = 1'b1;
      end else if (ifa.tx_state_in == TX_CMD_SEND && a_delay > 0) a_cnt = a_delay;
    end
  end

  initial begin
    ifb.tx_finish_fsm = 1'b0;
    b_cnt = 0;
    forever begin
      @(negedge clk);
      ifb.tx_finish_fsm = 1'b0;
      if (!rst) b_cnt = 0;
      else if (b_cnt > 0) begin
        b_cnt--;
        if (b_cnt == 0) ifb.tx_finish_fsm = 1'b1;
      end else if (ifb.tx_state_in == TX_CMD_SEND && b_delay > 0) b_cnt = b_delay;
    end
  end

  // Monitor: every ack pulse must match the oldest expectation for that instance.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ifa.ack != '0) begin
        if (exp_a.size() == 0) check("a_unexpected_ack", 64'(ifa.ack), 64'd0);
        else begin
          e = exp_a.pop_front();
          check("a_ack",     64'(ifa.ack),       64'd1 << e.idx);
          check("a_ack_err", 64'(ifa.ack_err),   64'(e.err));
          check("a_grant",   64'(ifa.grant_idx), 64'(e.idx));
          check("a_data",    64'(ifa.tx_data),   64'(e.data));
        end
      end else if (ifa.ack_err) check("a_err_without_ack", 64'(ifa.ack_err), 64'd0);
      if (ifb.ack != '0) begin
        if (exp_b.size() == 0) check("b_unexpected_ack", 64'(ifb.ack), 64'd0);
        else begin
          e = exp_b.pop_front();
          check("b_ack",     64'(ifb.ack),       64'd1 << e.idx);
          check("b_ack_err", 64'(ifb.ack_err),   64'(e.err));
          check("b_grant",   64'(ifb.grant_idx), 64'(e.idx));
          check("b_data",    64'(ifb.tx_data),   64'(e.data));
        end
      end else if (ifb.ack_err) check("b_err_without_ack", 64'(ifb.ack_err), 64'd0);
    end
  end

  // Advances negedges until an ack is seen; n = cycles advanced.
  task automatic wait_ack(input bit sel_b, input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((sel_b ? ifb.ack : ifa.ack) == '0) && n < limit);
    if ((sel_b ? ifb.ack : ifa.ack) == '0) check("ack_wait_expired", 64'(n), 64'(limit + 1));
  endtask

  initial begin
    #300000;
    $display("FAIL global_time_limit: got %0t expected below 300000", $time);
    $fatal(1);
  end

  initial begin
    int n;
    int bad;
    n_vec = 0; n_err = 0;
    a_delay = 0; b_delay = 0; a_stray = 1'b0;
    rst = 1'b0;
    ifa.req = '0; ifa.req_data = '0;
    ifb.req = '0; ifb.req_data = '0;
    repeat (3) @(negedge clk);
    check("rst_ack",     64'(ifa.ack),         64'd0);
    check("rst_ack_err", 64'(ifa.ack_err),     64'd0);
    check("rst_busy",    64'(ifa.busy),        64'd0);
    check("rst_grant",   64'(ifa.grant_idx),   64'd0);
    check("rst_cmd",     64'(ifa.tx_state_in), 64'd0);
    check("rst_data",    64'(ifa.tx_data),     64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Timeout abort of requester 0, then requester 1 with finish on the watchdog limit cycle
    ifb.req_data = {32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'h1111_0000};
    exp_b.push_back('{idx: 0, err: 1'b1, data: 32'h1111_0000});
    exp_b.push_back('{idx: 1, err: 1'b0, data: 32'h2222_0001});
    ifb.req = 4'b0011;
    @(negedge clk);
    check("b_launch_cmd", 64'(ifb.tx_state_in), 64'(TX_CMD_SEND));
    @(negedge clk);
    check("b_wait_cmd", 64'(ifb.tx_state_in), 64'(TX_CMD_IDLE));
    wait_ack(1'b1, 40, n);
    check("b_abort_latency", 64'(n), 64'd16);
    ifb.req = 4'b0010;
    b_delay = 16;
    @(negedge clk);
    check("b_gap_busy", 64'(ifb.busy), 64'd1);
    @(negedge clk);
    check("b_idle_busy", 64'(ifb.busy), 64'd0);
    @(negedge clk);
    check("b_launch2_cmd", 64'(ifb.tx_state_in), 64'(TX_CMD_SEND));
    check("b_launch2_grant", 64'(ifb.grant_idx), 64'd1);
    @(negedge clk);
    wait_ack(1'b1, 40, n);
    check("b_tie_latency", 64'(n), 64'd16);
    ifb.req = '0;
    b_delay = 0;
    repeat (2) @(negedge clk);

    // Single transfer, finish 100 cycles after the send
    a_delay = 100;
    ifa.req_data[31:0] = 32'hA5A5_0F0F;
    exp_a.push_back('{idx: 0, err: 1'b0, data: 32'hA5A5_0F0F});
    ifa.req = 4'b0001;
    @(negedge clk);
    check("a1_launch_cmd",  64'(ifa.tx_state_in), 64'(TX_CMD_SEND));
    check("a1_launch_busy", 64'(ifa.busy),        64'd1);
    check("a1_launch_data", 64'(ifa.tx_data),     64'hA5A5_0F0F);
    @(negedge clk);
    n = 0; bad = 0;
    while (ifa.ack == '0 && n < 200) begin
      if (ifa.tx_data !== 32'hA5A5_0F0F || ifa.tx_state_in !== TX_CMD_IDLE) bad++;
      @(negedge clk);
      n++;
    end
    check("a1_ack_latency", 64'(n), 64'd100);
    check("a1_wait_hold", 64'(bad), 64'd0);
    ifa.req = '0;
    @(negedge clk);
    check("a1_gap_busy", 64'(ifa.busy), 64'd1);
    check("a1_gap_ack",  64'(ifa.ack),  64'd0);
    @(negedge clk);
    check("a1_idle_busy", 64'(ifa.busy), 64'd0);

    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Round robin: all four pending, each drops after ack and re-raises a cycle later
    a_delay = 5;
    ifa.req_data = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
    exp_a.push_back('{idx: 0, err: 1'b0, data: 32'hAAAA_0000});
    exp_a.push_back('{idx: 1, err: 1'b0, data: 32'hBBBB_0001});
    exp_a.push_back('{idx: 2, err: 1'b0, data: 32'hCCCC_0002});
    exp_a.push_back('{idx: 3, err: 1'b0, data: 32'hDDDD_0003});
    exp_a.push_back('{idx: 0, err: 1'b0, data: 32'hAAAA_0000});
    exp_a.push_back('{idx: 1, err: 1'b0, data: 32'hBBBB_0001});
    ifa.req = 4'b1111;
    for (int t = 0; t < 6; t++) begin
      wait_ack(1'b0, 30, n);
      if (t == 5) ifa.req = '0;
      else begin
        ifa.req[t % 4] = 1'b0;
        @(negedge clk);
        ifa.req[t % 4] = 1'b1;
      end
    end
    repeat (2) @(negedge clk);

    // Data changed after grant is ignored; stray finish in IDLE is ignored
    a_delay = 20;
    ifa.req_data[95:64] = 32'hC0DE_0002;
    exp_a.push_back('{idx: 2, err: 1'b0, data: 32'hC0DE_0002});
    ifa.req = 4'b0100;
    @(negedge clk);
    check("a6_grant", 64'(ifa.grant_idx), 64'd2);
    @(negedge clk);
    ifa.req_data[95:64] = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    check("a6_data_held", 64'(ifa.tx_data), 64'hC0DE_0002);
    wait_ack(1'b0, 40, n);
    ifa.req = '0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 a_stray = 1'b1;
    @(posedge clk);
    #1 a_stray = 1'b0;
    repeat (3) @(negedge clk);
    check("a6_stray_busy", 64'(ifa.busy),        64'd0);
    check("a6_stray_cmd",  64'(ifa.tx_state_in), 64'd0);

    // Reset mid-WAIT: silent abort, outputs clear asynchronously, pointer back to 0
    a_delay = 50;
    ifa.req_data[127:96] = 32'h5555_0003;
    ifa.req = 4'b1000;
    @(negedge clk);
    check("a5_grant_before_rst", 64'(ifa.grant_idx), 64'd3);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    check("a5_rst_busy",  64'(ifa.busy),        64'd0);
    check("a5_rst_grant", 64'(ifa.grant_idx),   64'd0);
    check("a5_rst_data",  64'(ifa.tx_data),     64'd0);
    check("a5_rst_cmd",   64'(ifa.tx_state_in), 64'd0);
    check("a5_rst_ack",   64'({ifa.ack, ifa.ack_err}), 64'd0);
    ifa.req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    ifa.req_data[95:64]  = 32'h7777_0002;
    ifa.req_data[127:96] = 32'h8888_0003;
    exp_a.push_back('{idx: 2, err: 1'b0, data: 32'h7777_0002});
    ifa.req = 4'b1100;
    @(negedge clk);
    @(negedge clk);
    check("a5_grant_after_rst", 64'(ifa.grant_idx), 64'd2);
    wait_ack(1'b0, 80, n);
    ifa.req = '0;
    repeat (3) @(negedge clk);

    check("a_queue_drained", 64'(exp_a.size()), 64'd0);
    check("b_queue_drained", 64'(exp_b.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
